// File: rtl/graycode_pkg.sv
// Shared types and helpers for the gray-code step monitor.
// Optional saturating error counter is enabled by defining GRAY_MON_ERRCNT_EN.
package graycode_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } mon_state_t;

    // Widest code the decode helper supports; narrower codes are zero-extended.
    localparam int GRAY_MAX_W = 32;

    // Delta codes are sliced to WIDTH by the user: +1 and -1 (all-ones).
    localparam logic [GRAY_MAX_W-1:0] DELTA_UP = GRAY_MAX_W'(1);
    localparam logic [GRAY_MAX_W-1:0] DELTA_DN = '1;

    // Zero upper bits leave the xor-chain untouched, so one function serves any width.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/graycode_step_monitor_to_bin.sv
// Combinational WIDTH-bit gray-to-binary decoder.
module graycode_to_bin
    import graycode_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [GRAY_MAX_W-1:0] bin_wide;

    assign bin_wide = gray2bin(GRAY_MAX_W'(gray));
    assign bin      = bin_wide[WIDTH-1:0];

endmodule

// File: rtl/graycode_step_monitor.sv
// Gray-count checker and position tracker: classifies each sample as hold/+1/-1,
// accumulates position, latches a sticky fault on illegal jumps (GRAY_MON_ERRCNT_EN adds err_cnt).
module graycode_step_monitor
    import graycode_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             step,
    output logic             dir_up,
    output logic [POS_W-1:0] pos,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt
);

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;

    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] delta;
    logic             is_hold, is_up, is_dn;

    graycode_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (gray_in),
        .bin  (dec)
    );

    // Modular difference against the last accepted sample handles 7<->0 wrap for free.
    assign delta   = dec - bin_q;
    assign is_hold = (delta == '0);
    assign is_up   = (delta == DELTA_UP[WIDTH-1:0]);
    assign is_dn   = (delta == DELTA_DN[WIDTH-1:0]);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        pos_d   = pos_q;
        if (clr) begin
            state_d = UNLOCKED;
            pos_d   = '0;
            dir_d   = 1'b0;
        end else if (en) begin
            case (state_q)
                UNLOCKED: begin
                    bin_d   = dec;
                    state_d = LOCKED;
                end
                LOCKED: begin
                    if (is_up) begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = pos_q + POS_W'(1);
                        bin_d  = dec;
                    end else if (is_dn) begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = pos_q - POS_W'(1);
                        bin_d  = dec;
                    end else if (!is_hold) begin
                        state_d = FAULT;
                        bin_d   = dec;
                    end
                end
                FAULT: begin
                    bin_d = dec;
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= UNLOCKED;
            bin_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
        end
    end

    assign bin_out = bin_q;
    assign step    = step_q;
    assign dir_up  = dir_q;
    assign pos     = pos_q;
    assign locked  = (state_q == LOCKED);
    assign fault   = (state_q == FAULT);

`ifdef GRAY_MON_ERRCNT_EN
    logic [ERR_W-1:0] err_q, err_d;
    logic             illegal_jump;

    // Illegal jumps count in both LOCKED and FAULT; clr does not touch the counter.
    assign illegal_jump = en && !clr && (state_q != UNLOCKED) && !(is_hold || is_up || is_dn);

    always_comb begin
        err_d = err_q;
        if (illegal_jump && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_graycode_step_monitor.sv
// Directed self-checking bench for graycode_step_monitor (WIDTH=3, POS_W=8).
module tb_graycode_step_monitor;

`ifdef GRAY_MON_ERRCNT_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    logic       clk;
    logic       rstN;
    logic       en;
    logic       clr;
    logic [2:0] gray_in;
    logic [2:0] bin_out;
    logic       step;
    logic       dir_up;
    logic [7:0] pos;
    logic       locked;
    logic       fault;
    logic [3:0] err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    graycode_step_monitor #(.WIDTH(3), .POS_W(8), .ERR_W(4)) dut (
        .clk     (clk),
        .rstN    (rstN),
        .en      (en),
        .clr     (clr),
        .gray_in (gray_in),
        .bin_out (bin_out),
        .step    (step),
        .dir_up  (dir_up),
        .pos     (pos),
        .locked  (locked),
        .fault   (fault),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_bin, input logic e_step,
                           input logic e_dir, input logic [7:0] e_pos, input logic e_lock,
                           input logic e_fault, input int e_err);
        chk({tag, ".bin"},    32'(bin_out), 32'(e_bin));
        chk({tag, ".step"},   32'(step),    32'(e_step));
        chk({tag, ".dir"},    32'(dir_up),  32'(e_dir));
        chk({tag, ".pos"},    32'(pos),     32'(e_pos));
        chk({tag, ".locked"}, 32'(locked),  32'(e_lock));
        chk({tag, ".fault"},  32'(fault),   32'(e_fault));
        chk({tag, ".err"},    32'(err_cnt), 32'(ERR_ON * e_err));
    endtask

    // Apply inputs, let one rising edge take them, then sample 1ns later.
    task automatic drive(input logic e, input logic c, input logic [2:0] g);
        en      = e;
        clr     = c;
        gray_in = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] b;
        rstN = 1'b0; en = 1'b0; clr = 1'b0; gray_in = 3'b000;
        #2;
        chk_all("reset", 3'd0, 0, 0, 8'h00, 0, 0, 0);
        @(posedge clk); #1;
        rstN = 1'b1;

        // Lock, then count up 0..4
        drive(1, 0, 3'b000); chk_all("lock0", 3'd0, 0, 0, 8'h00, 1, 0, 0);
        drive(1, 0, 3'b001); chk_all("up1",   3'd1, 1, 1, 8'h01, 1, 0, 0);
        drive(1, 0, 3'b011); chk_all("up2",   3'd2, 1, 1, 8'h02, 1, 0, 0);
        drive(1, 0, 3'b010); chk_all("up3",   3'd3, 1, 1, 8'h03, 1, 0, 0);
        drive(1, 0, 3'b110); chk_all("up4",   3'd4, 1, 1, 8'h04, 1, 0, 0);
        // On up to 7 and wrap to 0
        drive(1, 0, 3'b111);
        drive(1, 0, 3'b101);
        drive(1, 0, 3'b100); chk_all("up7",   3'd7, 1, 1, 8'h07, 1, 0, 0);
        drive(1, 0, 3'b000); chk_all("wrap",  3'd0, 1, 1, 8'h08, 1, 0, 0);
        drive(0, 0, 3'b011); chk_all("en0",   3'd0, 0, 1, 8'h08, 1, 0, 0);
        drive(1, 0, 3'b000); chk_all("hold",  3'd0, 0, 1, 8'h08, 1, 0, 0);

        // Clear, relock at 0, then count down through wrap
        drive(0, 1, 3'b000); chk_all("clr",   3'd0, 0, 0, 8'h00, 0, 0, 0);
        drive(1, 0, 3'b000); chk_all("relock",3'd0, 0, 0, 8'h00, 1, 0, 0);
        drive(1, 0, 3'b100); chk_all("dn7",   3'd7, 1, 0, 8'hFF, 1, 0, 0);
        drive(1, 0, 3'b101); chk_all("dn6",   3'd6, 1, 0, 8'hFE, 1, 0, 0);
        drive(1, 0, 3'b111); chk_all("dn5",   3'd5, 1, 0, 8'hFD, 1, 0, 0);

        // 5 -> 0 is a jump of 3: fault; later samples only track bin_out
        drive(1, 0, 3'b000); chk_all("illeg", 3'd0, 0, 0, 8'hFD, 0, 1, 1);
        drive(1, 0, 3'b001); chk_all("fstep", 3'd1, 0, 0, 8'hFD, 0, 1, 1);
        drive(1, 0, 3'b010); chk_all("fillg", 3'd3, 0, 0, 8'hFD, 0, 1, 2);

        // clr wins over en; bin_out and err_cnt are retained
        drive(1, 1, 3'b110); chk_all("clren", 3'd3, 0, 0, 8'h00, 0, 0, 2);
        drive(1, 0, 3'b010); chk_all("lock3", 3'd3, 0, 0, 8'h00, 1, 0, 2);
        drive(1, 0, 3'b110); chk_all("up4b",  3'd4, 1, 1, 8'h01, 1, 0, 2);

        // Run up 126 more steps to +127, then overflow to -128
        b = 3'd4;
        for (int i = 0; i < 126; i++) begin
            b = b + 3'd1;
            drive(1, 0, b ^ (b >> 1));
        end
        chk_all("p127", 3'd2, 1, 1, 8'h7F, 1, 0, 2);
        drive(1, 0, 3'b010); chk_all("ovf",   3'd3, 1, 1, 8'h80, 1, 0, 2);

        // Asynchronous reset between edges
        en = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        chk_all("async", 3'd0, 0, 0, 8'h00, 0, 0, 0);
        rstN = 1'b1;
        drive(1, 0, 3'b011); chk_all("postrst", 3'd2, 0, 0, 8'h00, 1, 0, 0);
        drive(1, 0, 3'b010); chk_all("postup",  3'd3, 1, 1, 8'h01, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
